// File: rtl/uart_rx_param.sv
// uart_rx_param: parameterised UART receiver with parity, stop-bit,
// overrun and break detection, single-entry output holding register.
// Ports:
//   Rx_clk        clock, all state changes on rising edge
//   rst           synchronous active-low reset
//   Enable_Rx     receiver enable; low aborts a frame in progress
//   Pin           asynchronous serial line, idle high
//   Rx_Ack        consumer acknowledge of the held frame
//   Rx_Data       last received payload
//   Valid_Data    held frame available
//   Parity_Error  parity mismatch on held frame
//   Frame_Error   a stop bit sampled low on held frame
//   Overrun       a frame completed while Valid_Data was high
//   Break         line held low for a whole frame
//   Rx_busy       receiver not idle
module uart_rx_param #(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    Rx_clk,
  input  logic                    rst,
  input  logic                    Enable_Rx,
  input  logic                    Pin,
  input  logic                    Rx_Ack,
  output logic [PAYLOAD_BITS-1:0] Rx_Data,
  output logic                    Valid_Data,
  output logic                    Parity_Error,
  output logic                    Frame_Error,
  output logic                    Overrun,
  output logic                    Break,
  output logic                    Rx_busy
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_C  = CW'(CPB);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [3:0] LAST_D = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BRK
  } state_t;

  state_t state_q, state_d;

  logic                    sync1_q, sync2_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [3:0]              idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shf_q, shf_d;
  logic                    par_q, par_d;
  logic                    facc_q, facc_d;
  logic                    zero_q, zero_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    perr_q, perr_d;
  logic                    ferr_q, ferr_d;
  logic                    ovr_q, ovr_d;
  logic                    brk_q, brk_d;

  logic s;
  logic smp;
  logic abort;
  logic done;
  logic pchk;

  assign s     = sync2_q;
  assign smp   = (cnt_q == CPB_C);
  assign abort = !Enable_Rx && (state_q != ST_IDLE)
                 && (state_q != ST_BRK);
  assign pchk  = (^shf_q) ^ par_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shf_d   = shf_q;
    par_d   = par_q;
    facc_d  = facc_q;
    zero_d  = zero_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    brk_d   = brk_q;
    done    = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          if (Enable_Rx && !s) begin
            state_d = ST_START;
            cnt_d   = ONE_C;
          end
        end
        ST_START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == HALF_C) begin
            cnt_d   = s ? '0 : ONE_C;
            idx_d   = '0;
            zero_d  = 1'b1;
            facc_d  = 1'b0;
            state_d = s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          cnt_d = smp ? ONE_C : cnt_q + 1'b1;
          if (smp) begin
            shf_d  = {s, shf_q[PAYLOAD_BITS-1:1]};
            zero_d = zero_q & ~s;
            idx_d  = idx_q + 1'b1;
            if (idx_q == LAST_D) begin
              idx_d   = '0;
              state_d = (PARITY != 0) ? ST_PAR : ST_STOP;
            end
          end
        end
        ST_PAR: begin
          cnt_d = smp ? ONE_C : cnt_q + 1'b1;
          if (smp) begin
            par_d   = s;
            zero_d  = zero_q & ~s;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          cnt_d = smp ? ONE_C : cnt_q + 1'b1;
          if (smp) begin
            facc_d = facc_q | ~s;
            zero_d = zero_q & ~s;
            idx_d  = idx_q + 1'b1;
            if (idx_q == LAST_S) begin
              done    = 1'b1;
              cnt_d   = '0;
              idx_d   = '0;
              state_d = zero_d ? ST_BRK : ST_IDLE;
            end
          end
        end
        ST_BRK: begin
          cnt_d = '0;
          if (s) begin
            state_d = ST_IDLE;
            brk_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // a frame that was low throughout is a break, not data
    if (done && zero_d) begin
      brk_d = 1'b1;
    end else if (done) begin
      data_d  = shf_q;
      ferr_d  = facc_d;
      perr_d  = (PARITY == 1) ? ~pchk :
                (PARITY == 2) ?  pchk : 1'b0;
      valid_d = 1'b1;
      if (valid_q && !Rx_Ack) ovr_d = 1'b1;
    end else if (Rx_Ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge Rx_clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shf_q   <= '0;
      par_q   <= 1'b0;
      facc_q  <= 1'b0;
      zero_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= Pin;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shf_q   <= shf_d;
      par_q   <= par_d;
      facc_q  <= facc_d;
      zero_q  <= zero_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      brk_q   <= brk_d;
    end
  end

  assign Rx_Data      = data_q;
  assign Valid_Data   = valid_q;
  assign Parity_Error = perr_q;
  assign Frame_Error  = ferr_q;
  assign Overrun      = ovr_q;
  assign Break        = brk_q;
  assign Rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations (8N1, 8E2, 7O1)
// driven with serial frames built from a frame-level model.
module tb_uart_rx_param;

  int CPB [3] = '{16, 16, 13};
  int PB  [3] = '{8, 8, 7};
  int PR  [3] = '{0, 2, 1};
  int SB  [3] = '{1, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic en  [3];
  logic pin [3];
  logic ack [3];
  logic vld [3];
  logic pe  [3];
  logic fe  [3];
  logic ov  [3];
  logic bk  [3];
  logic bsy [3];
  logic [7:0] rxa, rxb;
  logic [6:0] rxc;

  int checks = 0;
  int errors = 0;

  logic tv [1024];
  logic tz [1024];
  logic tk [1024];

  uart_rx_param #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8),
    .PARITY(0), .STOP_BITS(1)) uA (
    .Rx_clk(clk), .rst(rst), .Enable_Rx(en[0]), .Pin(pin[0]),
    .Rx_Ack(ack[0]), .Rx_Data(rxa), .Valid_Data(vld[0]),
    .Parity_Error(pe[0]), .Frame_Error(fe[0]), .Overrun(ov[0]),
    .Break(bk[0]), .Rx_busy(bsy[0]));

  uart_rx_param #(.CLK_HZ(160), .BIT_RATE(10), .PAYLOAD_BITS(8),
    .PARITY(2), .STOP_BITS(2)) uB (
    .Rx_clk(clk), .rst(rst), .Enable_Rx(en[1]), .Pin(pin[1]),
    .Rx_Ack(ack[1]), .Rx_Data(rxb), .Valid_Data(vld[1]),
    .Parity_Error(pe[1]), .Frame_Error(fe[1]), .Overrun(ov[1]),
    .Break(bk[1]), .Rx_busy(bsy[1]));

  uart_rx_param #(.CLK_HZ(130), .BIT_RATE(10), .PAYLOAD_BITS(7),
    .PARITY(1), .STOP_BITS(1)) uC (
    .Rx_clk(clk), .rst(rst), .Enable_Rx(en[2]), .Pin(pin[2]),
    .Rx_Ack(ack[2]), .Rx_Data(rxc), .Valid_Data(vld[2]),
    .Parity_Error(pe[2]), .Frame_Error(fe[2]), .Overrun(ov[2]),
    .Break(bk[2]), .Rx_busy(bsy[2]));

  function automatic logic [8:0] rxd(input int i);
    case (i)
      0:       return {1'b0, rxa};
      1:       return {1'b0, rxb};
      default: return {2'b0, rxc};
    endcase
  endfunction

  // builds the line bit sequence of one frame and its expected result
  function automatic int mk(input int i, input logic [8:0] d,
                            input bit pflip, input logic [1:0] sv,
                            output logic [31:0] b,
                            output logic [8:0] ed,
                            output bit ep, output bit ef);
    int n;
    int ones;
    bit p;
    b  = '1;
    n  = 0;
    ep = 1'b0;
    ef = 1'b0;
    ed = d & ((9'd1 << PB[i]) - 9'd1);
    ones = $countones(ed);
    b[n[4:0]] = 1'b0;
    n++;
    for (int k = 0; k < PB[i]; k++) begin
      b[n[4:0]] = ed[k];
      n++;
    end
    if (PR[i] != 0) begin
      p = (PR[i] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
      p = p ^ pflip;
      b[n[4:0]] = p;
      n++;
      if (PR[i] == 1) ep = ((ones + int'(p)) % 2 == 0);
      else            ep = ((ones + int'(p)) % 2 == 1);
    end
    for (int k = 0; k < SB[i]; k++) begin
      b[n[4:0]] = sv[k];
      if (!sv[k]) ef = 1'b1;
      n++;
    end
    return n;
  endfunction

  // trace index c = cycle c after the start bit hits the line
  task automatic drive(input int i, input logic [31:0] b,
                       input int n, input int tail,
                       input int ack_at, input int en_off,
                       input int rst_at);
    int tot;
    int j;
    tot = n * CPB[i] + tail;
    @(negedge clk);
    pin[i] = b[0];
    for (int c = 0; c < tot; c++) begin
      @(negedge clk);
      tv[c] = vld[i];
      tz[c] = bsy[i];
      tk[c] = bk[i];
      ack[i] = (c == ack_at);
      if (c == en_off) en[i] = 1'b0;
      if (c == rst_at) rst = 1'b0;
      j = (c + 1) / CPB[i];
      pin[i] = (j < n) ? b[j[4:0]] : 1'b1;
    end
    ack[i] = 1'b0;
  endtask

  task automatic do_ack(input int i);
    ack[i] = 1'b1;
    @(negedge clk);
    ack[i] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({rxd(i), vld[i], pe[i], fe[i], ov[i], bk[i], bsy[i]}
          !== 15'd0) begin
        errors++;
        $display("FAIL reset_outs[%0d] got %h want 0", i,
          {rxd(i), vld[i], pe[i], fe[i], ov[i], bk[i], bsy[i]});
      end
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_latency;
    logic [31:0] b; logic [8:0] ed; bit ep, ef; int n, l;
    n = mk(0, 9'h0A5, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 4, -1, -1, -1);
    l = CPB[0] / 2 + 9 * CPB[0] + 2;
    checks++;
    if (tv[l-1] !== 1'b0) begin
      errors++; $display("FAIL lat_early got %b want 0", tv[l-1]);
    end
    checks++;
    if (tv[l] !== 1'b1) begin
      errors++; $display("FAIL lat_valid got %b want 1", tv[l]);
    end
    checks++;
    if (rxd(0) !== 9'h0A5) begin
      errors++; $display("FAIL lat_data got %h want a5", rxd(0));
    end
    checks++;
    if ({pe[0], fe[0], ov[0], bk[0]} !== 4'b0) begin
      errors++;
      $display("FAIL lat_flags got %b want 0000",
        {pe[0], fe[0], ov[0], bk[0]});
    end
    do_ack(0);
    checks++;
    if (vld[0] !== 1'b0) begin
      errors++; $display("FAIL lat_ack got %b want 0", vld[0]);
    end
  endtask

  task automatic test_random;
    logic [31:0] b; logic [8:0] d, ed, xd; bit ep, ef, xp, xf;
    bit pf, xv, xo; logic [1:0] sv; int n;
    for (int i = 0; i < 3; i++) begin
      xv = 1'b0; xo = 1'b0; xd = '0; xp = 1'b0; xf = 1'b0;
      for (int f = 0; f < 6; f++) begin
        d  = 9'($urandom);
        pf = (PR[i] != 0) ? bit'($urandom % 2) : 1'b0;
        sv = ($urandom % 3 == 0) ? 2'($urandom) : 2'b11;
        n  = mk(i, d, pf, sv, b, ed, ep, ef);
        if (((b >> 1) & ((32'd1 << (n - 1)) - 32'd1)) == 32'd0) begin
          sv = 2'b11;
          n  = mk(i, d, pf, sv, b, ed, ep, ef);
        end
        drive(i, b, n, 3, -1, -1, -1);
        xo = xo | xv; xv = 1'b1; xd = ed; xp = ep; xf = ef;
        checks++;
        if ({rxd(i), pe[i], fe[i]} !== {xd, xp, xf}) begin
          errors++;
          $display("FAIL rnd_frame[%0d] got %h/%b/%b want %h/%b/%b",
            i, rxd(i), pe[i], fe[i], xd, xp, xf);
        end
        checks++;
        if ({vld[i], ov[i], bk[i]} !== {xv, xo, 1'b0}) begin
          errors++;
          $display("FAIL rnd_flags[%0d] got %b want %b", i,
            {vld[i], ov[i], bk[i]}, {xv, xo, 1'b0});
        end
        if ($urandom % 2 == 1) begin
          do_ack(i);
          xv = 1'b0; xo = 1'b0;
          checks++;
          if ({vld[i], ov[i]} !== {xv, xo}) begin
            errors++;
            $display("FAIL rnd_ack[%0d] got %b want 00", i,
              {vld[i], ov[i]});
          end
        end
      end
      do_ack(i);
    end
  endtask

  task automatic test_parity;
    logic [31:0] b; logic [8:0] ed; bit ep, ef; int n;
    n = mk(1, 9'h03C, 1'b1, 2'b11, b, ed, ep, ef);
    drive(1, b, n, 3, -1, -1, -1);
    checks++;
    if ({rxd(1), pe[1], fe[1]} !== {9'h03C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL par_bad got %h/%b/%b want 3c/1/0",
        rxd(1), pe[1], fe[1]);
    end
    do_ack(1);
    n = mk(1, 9'h03C, 1'b0, 2'b11, b, ed, ep, ef);
    drive(1, b, n, 3, -1, -1, -1);
    checks++;
    if ({rxd(1), pe[1], vld[1]} !== {9'h03C, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL par_ok got %h/%b/%b want 3c/0/1",
        rxd(1), pe[1], vld[1]);
    end
    do_ack(1);
  endtask

  task automatic test_glitch;
    int h;
    h = CPB[0] / 2;
    @(negedge clk);
    pin[0] = 1'b0;
    for (int c = 0; c < h + 6; c++) begin
      @(negedge clk);
      tz[c] = bsy[0];
      tv[c] = vld[0];
      if (c == 4) pin[0] = 1'b1;
    end
    checks++;
    if ({tz[2], tz[h+1]} !== 2'b11) begin
      errors++;
      $display("FAIL glitch_busy got %b want 11", {tz[2], tz[h+1]});
    end
    checks++;
    if ({tz[h+2], tv[h+5]} !== 2'b00) begin
      errors++;
      $display("FAIL glitch_idle got %b want 00", {tz[h+2], tv[h+5]});
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] b; logic [8:0] ed; bit ep, ef; int n, fs;
    fs = CPB[0] / 2 + 9 * CPB[0] + 1;
    n = mk(0, 9'h011, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 0, -1, -1, -1);
    n = mk(0, 9'h022, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 3, -1, -1, -1);
    checks++;
    if ({rxd(0), vld[0], ov[0]} !== {9'h022, 2'b11}) begin
      errors++;
      $display("FAIL b2b_ovr got %h/%b/%b want 22/1/1",
        rxd(0), vld[0], ov[0]);
    end
    do_ack(0);
    checks++;
    if ({vld[0], ov[0]} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_ack got %b want 00", {vld[0], ov[0]});
    end
    n = mk(0, 9'h033, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 0, -1, -1, -1);
    n = mk(0, 9'h034, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 0, -1, -1, -1);
    n = mk(0, 9'h044, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 3, fs, -1, -1);
    checks++;
    if ({tv[fs], tv[fs+1]} !== 2'b11) begin
      errors++;
      $display("FAIL coin_valid got %b want 11", {tv[fs], tv[fs+1]});
    end
    checks++;
    if ({rxd(0), ov[0]} !== {9'h044, 1'b1}) begin
      errors++;
      $display("FAIL coin_data got %h/%b want 44/1", rxd(0), ov[0]);
    end
    do_ack(0);
  endtask

  task automatic test_break;
    logic [31:0] b; logic [8:0] ed; bit ep, ef; int n, l, e;
    n = mk(0, 9'h05A, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 3, -1, -1, -1);
    drive(0, 32'h0, 20, 6, -1, -1, -1);
    l = CPB[0] / 2 + 9 * CPB[0] + 2;
    e = 20 * CPB[0] - 1;
    checks++;
    if ({tk[l-1], tk[l], tk[e]} !== 3'b011) begin
      errors++;
      $display("FAIL brk_set got %b want 011", {tk[l-1], tk[l], tk[e]});
    end
    checks++;
    if ({tv[e], rxd(0)} !== {1'b1, 9'h05A}) begin
      errors++;
      $display("FAIL brk_hold got %b/%h want 1/5a", tv[e], rxd(0));
    end
    checks++;
    if ({tk[e+3], tz[e+3]} !== 2'b00) begin
      errors++;
      $display("FAIL brk_clr got %b want 00", {tk[e+3], tz[e+3]});
    end
    do_ack(0);
  endtask

  task automatic test_enable;
    logic [31:0] b; logic [8:0] ed; bit ep, ef; int n, k;
    k = 3 * CPB[0];
    n = mk(0, 9'h00F, 1'b0, 2'b11, b, ed, ep, ef);
    drive(0, b, n, 3, -1, k, -1);
    checks++;
    if ({tz[k], tz[k+1], tz[100]} !== 3'b100) begin
      errors++;
      $display("FAIL en_abort got %b want 100",
        {tz[k], tz[k+1], tz[100]});
    end
    checks++;
    if (tv[n * CPB[0] + 2] !== 1'b0) begin
      errors++;
      $display("FAIL en_valid got %b want 0", tv[n * CPB[0] + 2]);
    end
    en[0] = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stop2;
    logic [31:0] b; logic [8:0] ed; bit ep, ef; int n;
    n = mk(1, 9'h055, 1'b0, 2'b01, b, ed, ep, ef);
    drive(1, b, n, 3, -1, -1, -1);
    checks++;
    if ({rxd(1), fe[1], pe[1], vld[1]} !== {9'h055, 3'b101}) begin
      errors++;
      $display("FAIL stop2 got %h/%b/%b/%b want 55/1/0/1",
        rxd(1), fe[1], pe[1], vld[1]);
    end
    n = mk(1, 9'h012, 1'b0, 2'b11, b, ed, ep, ef);
    drive(1, b, n, 3, -1, -1, 4 * CPB[1]);
    checks++;
    if ({rxd(1), vld[1], pe[1], fe[1], ov[1], bk[1], bsy[1]}
        !== 15'd0) begin
      errors++;
      $display("FAIL mid_rst got %h want 0",
        {rxd(1), vld[1], pe[1], fe[1], ov[1], bk[1], bsy[1]});
    end
    rst = 1'b1;
    n = mk(1, 9'h09C, 1'b0, 2'b11, b, ed, ep, ef);
    drive(1, b, n, 3, -1, -1, -1);
    checks++;
    if ({rxd(1), vld[1], fe[1], pe[1]} !== {9'h09C, 3'b100}) begin
      errors++;
      $display("FAIL rearm got %h/%b/%b/%b want 9c/1/0/0",
        rxd(1), vld[1], fe[1], pe[1]);
    end
    do_ack(1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      en[i]  = 1'b1;
      pin[i] = 1'b1;
      ack[i] = 1'b0;
    end
    test_reset;
    test_latency;
    test_random;
    test_parity;
    test_glitch;
    test_back_to_back;
    test_break;
    test_enable;
    test_stop2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
